lane_grant_scheduler: RTL and testbench



---
 rtl/lane_grant_scheduler_if.sv | 23 ++
 rtl/lane_grant_scheduler.sv | 149 ++++++++++++++
 tb/tb_lane_grant_scheduler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/lane_grant_scheduler_if.sv
// Request/grant bundle between the lane grant scheduler and the PE requesters.
// Handshake: req[k] is a level request; a grant is live while gnt_valid=1 and
// ends on a one-cycle done pulse, on req[gnt_idx] dropping, or on preempt.
interface lane_grant_scheduler_if;
   logic        en;
   logic [15:0] req;
   logic        done;
   logic        gnt_valid;
   logic [3:0]  gnt_idx;
   logic [15:0] gnt_onehot;
   logic        preempt;
   logic        busy;

   modport master (
      input  en, req, done,
      output gnt_valid, gnt_idx, gnt_onehot, preempt, busy
   );

   modport slave (
      output en, req, done,
      input  gnt_valid, gnt_idx, gnt_onehot, preempt, busy
   );
endinterface

// File: rtl/lane_grant_scheduler.sv
// Round-robin owner of the shared 4-to-16 lane-select decoder, with an idle gap between owners.
// Optional macro ARB_TIMEOUT_EN adds a hold-time limit that preempts an owner when others wait.
module lane_grant_scheduler #(
   parameter int N_REQ    = 16,
   parameter int IDX_W    = 4,
   parameter int GAP_CYC  = 2,
   parameter int HOLD_MAX = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   lane_grant_scheduler_if.master     bus,
   output logic [1:0]                 dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [3:0]         gap_q, gap_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               valid_q, valid_d;
   logic [N_REQ-1:0]   onehot_q, onehot_d;
   logic               preempt_q, preempt_d;
   logic               busy_q, busy_d;

   logic               found;
   logic [IDX_W-1:0]   pick;
   logic [IDX_W-1:0]   cand;
   logic               release_own;
   logic               timeout_hit;

   // First set request at or above ptr, wrapping 15->0 through 4-bit arithmetic.
   always_comb begin
      found = 1'b0;
      pick  = ptr_q;
      cand  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = ptr_q + IDX_W'(i);
         if (!found && bus.req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign release_own = bus.done || !bus.req[idx_q];

`ifdef ARB_TIMEOUT_EN
   localparam int HOLD_W = $clog2(HOLD_MAX);

   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [N_REQ-1:0]   owner_mask;
   logic               others_waiting;

   assign owner_mask     = N_REQ'(1) << idx_q;
   assign others_waiting = |(bus.req & ~owner_mask);
   assign timeout_hit    = (hold_q == HOLD_W'(HOLD_MAX - 1)) && others_waiting;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) hold_q <= '0;
      else        hold_q <= hold_d;
   end

   always_comb begin
      hold_d = hold_q;
      if (state_q == IDLE)
         hold_d = '0;
      else if (state_q == OWN && hold_q != HOLD_W'(HOLD_MAX - 1))
         hold_d = hold_q + HOLD_W'(1);
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         gap_q     <= '0;
         idx_q     <= '0;
         valid_q   <= 1'b0;
         onehot_q  <= '0;
         preempt_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gap_q     <= gap_d;
         idx_q     <= idx_d;
         valid_q   <= valid_d;
         onehot_q  <= onehot_d;
         preempt_q <= preempt_d;
         busy_q    <= busy_d;
      end
   end

   // Outputs are computed from the next state so every port comes straight off a flop.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gap_d     = gap_q;
      idx_d     = idx_q;
      valid_d   = valid_q;
      onehot_d  = onehot_q;
      preempt_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.en && found) begin
               state_d  = OWN;
               idx_d    = pick;
               valid_d  = 1'b1;
               onehot_d = {1'b1, {(N_REQ-1){1'b0}}} >> pick;
               ptr_d    = pick + IDX_W'(1);
            end
         end
         OWN: begin
            if (release_own || timeout_hit) begin
               state_d   = GAP;
               valid_d   = 1'b0;
               onehot_d  = '0;
               gap_d     = '0;
               preempt_d = !release_own;
            end
         end
         GAP: begin
            if (gap_q == 4'(GAP_CYC - 1)) begin
               state_d = IDLE;
               gap_d   = '0;
            end else begin
               gap_d = gap_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   assign bus.gnt_valid  = valid_q;
   assign bus.gnt_idx    = idx_q;
   assign bus.gnt_onehot = onehot_q;
   assign bus.preempt    = preempt_q;
   assign bus.busy       = busy_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_lane_grant_scheduler.sv
// Directed bench for lane_grant_scheduler: round-robin order, gap timing, en gating, reset, timeout.
module tb_lane_grant_scheduler;

   localparam int GAP_CYC = 2;

   logic       clk;
   logic       reset;
   logic [1:0] dbg_state;
   int         checks;
   int         failures;

   lane_grant_scheduler_if bus ();

   lane_grant_scheduler #(
      .N_REQ   (16),
      .IDX_W   (4),
      .GAP_CYC (GAP_CYC),
      .HOLD_MAX(64)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_grant(input string tag, input int exp_cyc, input logic [3:0] exp_idx);
      int n;
      n = 0;
      while (bus.gnt_valid !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'(exp_cyc));
      chk({tag, "_idx"}, 32'(bus.gnt_idx), 32'(exp_idx));
      chk({tag, "_onehot"}, 32'(bus.gnt_onehot), 32'(16'h8000 >> exp_idx));
   endtask

   task automatic release_and_regrant(input string tag, input logic [3:0] exp_idx);
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      chk({tag, "_fall"}, 32'(bus.gnt_valid), 32'd0);
      wait_grant(tag, GAP_CYC + 1, exp_idx);
   endtask

   initial begin
      int pre_seen;
      int n;
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      bus.en   = 1'b0;
      bus.req  = '0;
      bus.done = 1'b0;
      step();
      step();
      chk("rst_valid", 32'(bus.gnt_valid), 32'd0);
      chk("rst_idx", 32'(bus.gnt_idx), 32'd0);
      chk("rst_onehot", 32'(bus.gnt_onehot), 32'd0);
      chk("rst_preempt", 32'(bus.preempt), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'd0);

      // First grant from IDLE arrives one cycle after the request.
      reset   = 1'b1;
      bus.en  = 1'b1;
      bus.req = 16'h0001;
      wait_grant("first", 1, 4'd0);
      chk("first_busy", 32'(bus.busy), 32'd1);

      // Two persistent requesters alternate; ptr=1 so idx 15 comes next.
      bus.req = 16'h8001;
      release_and_regrant("alt1", 4'd15);
      release_and_regrant("alt2", 4'd0);
      release_and_regrant("alt3", 4'd15);
      release_and_regrant("alt4", 4'd0);

      // Owner 0 released by its request dropping; then idx 5 released the same way.
      bus.req = 16'h0020;
      step();
      chk("drop0_valid", 32'(bus.gnt_valid), 32'd0);
      chk("drop0_idx", 32'(bus.gnt_idx), 32'd0);
      wait_grant("own5", GAP_CYC + 1, 4'd5);
      bus.req = 16'h0000;
      step();
      chk("drop5_valid", 32'(bus.gnt_valid), 32'd0);
      chk("drop5_onehot", 32'(bus.gnt_onehot), 32'd0);
      chk("drop5_idx", 32'(bus.gnt_idx), 32'd5);

      // en=0 in IDLE blocks grants; raising en grants the index at ptr (6).
      bus.en  = 1'b0;
      bus.req = 16'hFFFF;
      repeat (8) step();
      chk("en0_valid", 32'(bus.gnt_valid), 32'd0);
      chk("en0_busy", 32'(bus.busy), 32'd0);
      bus.en = 1'b1;
      wait_grant("en1", 1, 4'd6);

      // en=0 while owning leaves the owner alone until done.
      bus.en = 1'b0;
      repeat (5) step();
      chk("en0own_valid", 32'(bus.gnt_valid), 32'd1);
      chk("en0own_idx", 32'(bus.gnt_idx), 32'd6);
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      chk("en0own_fall", 32'(bus.gnt_valid), 32'd0);
      repeat (6) step();
      chk("en0gap_valid", 32'(bus.gnt_valid), 32'd0);
      bus.en = 1'b1;
      wait_grant("en1b", 1, 4'd7);

      // Reach owner 9, then reset asynchronously mid-grant.
      bus.req = 16'h0200;
      release_and_regrant("own9", 4'd9);
      #2 reset = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.gnt_valid), 32'd0);
      chk("arst_idx", 32'(bus.gnt_idx), 32'd0);
      chk("arst_onehot", 32'(bus.gnt_onehot), 32'd0);
      chk("arst_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      reset   = 1'b1;
      bus.req = 16'h8004;
      wait_grant("post_rst", 1, 4'd2);

      // Owner 2 with requester 7 competing.
      bus.req  = 16'h0084;
      pre_seen = 0;
      n        = 0;
`ifdef ARB_TIMEOUT_EN
      while (bus.preempt !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      chk("to_preempt_cyc", 32'(n), 32'd64);
      chk("to_fall", 32'(bus.gnt_valid), 32'd0);
      step();
      chk("to_preempt_pulse", 32'(bus.preempt), 32'd0);
      wait_grant("to_next", GAP_CYC, 4'd7);
`else
      repeat (80) begin
         step();
         if (bus.preempt !== 1'b0) pre_seen++;
      end
      chk("nto_preempt", 32'(pre_seen), 32'd0);
      chk("nto_valid", 32'(bus.gnt_valid), 32'd1);
      chk("nto_idx", 32'(bus.gnt_idx), 32'd2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
